vend_txn_ctrl: RTL and testbench
================================

// Module: vend_txn_ctrl
// PURPOSE
//  Transaction controller for a multi-product vending machine.
//  - Accumulates coin credit.
//  - Validates product selections against per-product prices.
//  - Sequences the dispense mechanism and then the change-coin ejector via req/ack handshakes.
//  - Sits between the coin acceptor/keypad front end and the dispenser/ejector actuators.
// PARAMETERS
//  PRICE0     3     price of product 0, in Rs.5 units (3 = Rs.15)
//  PRICE1     4     price of product 1, Rs.5 units
//  PRICE2     2     price of product 2, Rs.5 units
//  PRICE3     5     price of product 3, Rs.5 units
//  MAX_CREDIT 10    max credit held, Rs.5 units (Rs.50); must be < 16
//  TIMEOUT    1000  idle cycles with credit>0 before auto-refund; must be >= 2
// PORTS
//  clk         in   1  clock; all state updates on posedge
//  rst         in   1  synchronous reset, active-high
//  in          in   2  coin this cycle: 00 none, 01 Rs.5, 10 Rs.10, 11 invalid
//  sel_valid   in   1  product selection strobe, 1 cycle
//  sel         in   2  product id, sampled when sel_valid=1
//  cancel      in   1  refund request, 1 cycle
//  disp_ack    in   1  dispenser done; valid only while disp_req=1
//  chg_ack     in   1  ejector released one Rs.5 coin; valid only while chg_req=1
//  disp_req    out  1  dispense request, held until disp_ack
//  disp_id     out  2  product to dispense, stable while disp_req=1
//  chg_req     out  1  eject one Rs.5 coin per handshake
//  credit      out  4  current credit, Rs.5 units
//  coin_reject out  1  1-cycle pulse: coin not credited (return it)
//  sel_nak     out  1  1-cycle pulse: selection refused (insufficient credit)
//  busy        out  1  1 in DISPENSE or CHANGE
// BEHAVIOUR
//  Reset
//  - All outputs and registers are 0; state = COLLECT.
//  - rst mid-transaction aborts the transaction; credit is discarded.
//  Registered outputs
//  - All outputs are registered and respond 1 cycle after the causing input edge.
//  States
//  - COLLECT (coins and selections accepted), DISPENSE, CHANGE.
//  COLLECT, coins
//  - in=01 adds 1 to credit; in=10 adds 2.
//  - in=11, or a coin that would make credit > MAX_CREDIT: not credited, coin_reject=1.
//  COLLECT, selection
//  - sel_valid with credit >= PRICE[sel]: latch disp_id=sel, credit -= PRICE[sel], go DISPENSE.
//  - disp_req=1 from the next cycle.
//  - Otherwise sel_nak=1 and state is unchanged.
//  COLLECT, simultaneous events (same cycle)
//  - coin + sel_valid: price is checked against the pre-coin credit.
//  - If the selection is accepted: credit_next = credit + coin - price; the coin's overflow check uses this value.
//  - If the selection is refused: the coin is handled as a normal COLLECT coin.
//  - cancel beats sel_valid: the selection is ignored with no sel_nak; any coin is still credited.
//  COLLECT, cancel
//  - With resulting credit > 0: go CHANGE.
//  - With credit 0: no effect.
//  Timeout
//  - Idle counter clears on any coin, sel_valid or cancel, and while credit = 0.
//  - When it reaches TIMEOUT with credit > 0: go CHANGE (same as cancel).
//  DISPENSE
//  - disp_req held 1, disp_id held stable.
//  - On disp_ack: disp_req=0 next cycle; go CHANGE if credit > 0, else COLLECT.
//  CHANGE
//  - chg_req=1 while credit > 0.
//  - Each cycle with chg_req & chg_ack: credit -= 1. Back-to-back acks are allowed (1 coin/cycle).
//  - The ack that takes credit to 0: chg_req=0 next cycle, state -> COLLECT.
//  DISPENSE / CHANGE, other inputs
//  - Any coin (01, 10, 11): coin_reject=1, not credited.
//  - sel_valid: ignored, no sel_nak.
//  - cancel: ignored.
//  - Stray acks: disp_ack outside DISPENSE and chg_ack with chg_req=0 are ignored.
//  Arithmetic
//  - 4-bit unsigned credit.
//  - Cannot underflow, because the price is checked before subtraction.
// TESTING
//  1. Insert 01,01,01, then sel_valid sel=0 -> credit 3 -> 0, disp_req=1, disp_id=0; disp_ack -> COLLECT, no chg_req.
//  2. Insert 10,10, then sel=0 (price 3) -> dispense; after ack, exactly 1 chg_req/chg_ack handshake; credit 0, busy=0.
//  3. Insert 01, then sel=3 -> sel_nak 1 cycle, credit stays 1; cancel -> 1 change coin, then COLLECT.
//  4. Insert 10 x5 (credit 10), then one more 10 -> coin_reject=1, credit stays 10; in=11 in COLLECT -> coin_reject=1.
//  5. Insert 01, then idle TIMEOUT cycles -> chg_req asserted, 1 coin refunded; coin inserted during DISPENSE -> coin_reject=1.
//  6. rst asserted mid-DISPENSE with credit 2 -> next cycle all outputs 0, state COLLECT; later disp_ack ignored.

Source files
------------

// File: rtl/vend_txn_ctrl.sv
// Vending machine transaction controller: coin credit, product
// selection, dispense handshake and change-coin ejection.
module vend_txn_ctrl #(
    parameter int PRICE0     = 3,
    parameter int PRICE1     = 4,
    parameter int PRICE2     = 2,
    parameter int PRICE3     = 5,
    parameter int MAX_CREDIT = 10,
    parameter int TIMEOUT    = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in,
    input  logic       sel_valid,
    input  logic [1:0] sel,
    input  logic       cancel,
    input  logic       disp_ack,
    input  logic       chg_ack,
    output logic       disp_req,
    output logic [1:0] disp_id,
    output logic       chg_req,
    output logic [3:0] credit,
    output logic       coin_reject,
    output logic       sel_nak,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        COLLECT,
        DISPENSE,
        CHANGE
    } state_t;

    state_t        state;
    logic [TW-1:0] idle_cnt;

    logic [3:0] coin_amt;
    logic       coin_bad;
    logic [3:0] price;
    logic       take;
    logic [3:0] base;
    logic [4:0] sum;
    logic       coin_fits;
    logic [3:0] new_credit;
    logic       reject;

    // Coin value, selected price and the post-event credit in COLLECT
    always_comb begin
        coin_amt = 4'd0;
        coin_bad = 1'b0;
        unique case (in)
            2'b01:   coin_amt = 4'd1;
            2'b10:   coin_amt = 4'd2;
            2'b11:   coin_bad = 1'b1;
            default: coin_amt = 4'd0;
        endcase
        unique case (sel)
            2'd0:    price = 4'(PRICE0);
            2'd1:    price = 4'(PRICE1);
            2'd2:    price = 4'(PRICE2);
            default: price = 4'(PRICE3);
        endcase
        // price is judged on pre-coin credit; the coin lands on what remains
        take       = sel_valid && !cancel && (credit >= price);
        base       = take ? (credit - price) : credit;
        sum        = {1'b0, base} + {1'b0, coin_amt};
        coin_fits  = (sum <= 5'(MAX_CREDIT));
        reject     = coin_bad || !coin_fits;
        new_credit = reject ? base : sum[3:0];
    end

    // Transaction state machine with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COLLECT;
            idle_cnt    <= '0;
            credit      <= 4'd0;
            disp_req    <= 1'b0;
            disp_id     <= 2'd0;
            chg_req     <= 1'b0;
            coin_reject <= 1'b0;
            sel_nak     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            sel_nak     <= 1'b0;
            unique case (state)
                COLLECT: begin
                    credit      <= new_credit;
                    coin_reject <= reject;
                    if (take) begin
                        state    <= DISPENSE;
                        disp_req <= 1'b1;
                        disp_id  <= sel;
                        busy     <= 1'b1;
                        idle_cnt <= '0;
                    end else if (cancel) begin
                        idle_cnt <= '0;
                        if (new_credit != 4'd0) begin
                            state   <= CHANGE;
                            chg_req <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end else begin
                        sel_nak <= sel_valid;
                        if (sel_valid || (in != 2'b00) ||
                            (credit == 4'd0)) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
                            idle_cnt <= '0;
                            state    <= CHANGE;
                            chg_req  <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                DISPENSE: begin
                    coin_reject <= (in != 2'b00);
                    if (disp_ack) begin
                        disp_req <= 1'b0;
                        if (credit != 4'd0) begin
                            state   <= CHANGE;
                            chg_req <= 1'b1;
                        end else begin
                            state <= COLLECT;
                            busy  <= 1'b0;
                        end
                    end
                end
                CHANGE: begin
                    coin_reject <= (in != 2'b00);
                    if (chg_req && chg_ack) begin
                        credit <= credit - 4'd1;
                        if (credit == 4'd1) begin
                            chg_req <= 1'b0;
                            state   <= COLLECT;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Bench for vend_txn_ctrl: directed vector table, timeout sequence
// and random traffic against a transaction-level reference model.
module tb_vend_txn_ctrl;

    localparam int TMO = 16;
    localparam int MAXC = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] in = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       cancel = 1'b0;
    logic       disp_ack = 1'b0;
    logic       chg_ack = 1'b0;
    logic       disp_req;
    logic [1:0] disp_id;
    logic       chg_req;
    logic [3:0] credit;
    logic       coin_reject;
    logic       sel_nak;
    logic       busy;

    int errors = 0;
    int checks = 0;

    vend_txn_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .in(in),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
        .disp_ack(disp_ack), .chg_ack(chg_ack),
        .disp_req(disp_req), .disp_id(disp_id),
        .chg_req(chg_req), .credit(credit),
        .coin_reject(coin_reject), .sel_nak(sel_nak),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] in;
        logic       sv;
        logic [1:0] sel;
        logic       can;
        logic       dack;
        logic       cack;
        logic [3:0] cr;
        logic       dr;
        logic [1:0] id;
        logic       cq;
        logic       rej;
        logic       nak;
        logic       bsy;
    } vec_t;

    vec_t tv[$];

    function automatic void add(
        input logic r, input logic [1:0] i, input logic sv,
        input logic [1:0] s, input logic c, input logic da,
        input logic ca, input logic [3:0] cr, input logic dr,
        input logic [1:0] id, input logic cq, input logic rej,
        input logic nak, input logic bsy);
        vec_t v;
        v.rst = r; v.in = i; v.sv = sv; v.sel = s; v.can = c;
        v.dack = da; v.cack = ca; v.cr = cr; v.dr = dr;
        v.id = id; v.cq = cq; v.rej = rej; v.nak = nak;
        v.bsy = bsy;
        tv.push_back(v);
    endfunction

    function automatic logic [10:0] outs();
        return {credit, disp_req, disp_id, chg_req,
                coin_reject, sel_nak, busy};
    endfunction

    task automatic check(input string name,
                         input logic [10:0] got,
                         input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got cr/dr/id/cq/rej/nak/bsy=%b exp=%b",
                     name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] i,
                         input logic sv, input logic [1:0] s,
                         input logic c, input logic da,
                         input logic ca);
        rst = r; in = i; sel_valid = sv; sel = s;
        cancel = c; disp_ack = da; chg_ack = ca;
        @(posedge clk);
        #1;
    endtask

    // reference model: mode 0 collect, 1 dispense, 2 change
    int m_mode, m_cr, m_id, m_idle;
    bit m_rej, m_nak;
    int prices[4] = '{3, 4, 2, 5};

    function automatic void model(
        input logic r, input logic [1:0] i, input logic sv,
        input logic [1:0] s, input logic c, input logic da,
        input logic ca);
        int coin, left;
        bit take;
        m_rej = 0;
        m_nak = 0;
        if (r) begin
            m_mode = 0; m_cr = 0; m_id = 0; m_idle = 0;
            return;
        end
        coin = (i == 2'b01) ? 1 : (i == 2'b10) ? 2 : 0;
        if (m_mode == 0) begin
            take = sv && !c && (m_cr >= prices[s]);
            if (sv && !c && !take) m_nak = 1;
            left = take ? m_cr - prices[s] : m_cr;
            if (i == 2'b11 || left + coin > MAXC) m_rej = 1;
            else left = left + coin;
            m_cr = left;
            if (take) begin
                m_mode = 1; m_id = s; m_idle = 0;
            end else if (c) begin
                m_idle = 0;
                if (m_cr > 0) m_mode = 2;
            end else if (i != 0 || sv || m_cr == 0) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_mode = 2; m_idle = 0;
                end
            end
        end else if (m_mode == 1) begin
            m_rej = (i != 0);
            if (da) m_mode = (m_cr > 0) ? 2 : 0;
        end else begin
            m_rej = (i != 0);
            if (ca) begin
                m_cr--;
                if (m_cr == 0) m_mode = 0;
            end
        end
    endfunction

    function automatic logic [10:0] model_outs();
        return {4'(m_cr), m_mode == 1, 2'(m_id), m_mode == 2,
                m_rej, m_nak, m_mode != 0};
    endfunction

    initial begin
        // rst in  sv sel can da ca | cr dr id cq rej nak bsy
        add(1,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        add(0,1,0,0,0,0,0, 1,0,0,0,0,0,0);
        add(0,1,0,0,0,0,0, 2,0,0,0,0,0,0);
        add(0,1,0,0,0,0,0, 3,0,0,0,0,0,0);
        add(0,0,1,0,0,0,0, 0,1,0,0,0,0,1);
        add(0,0,0,0,0,0,0, 0,1,0,0,0,0,1);
        add(0,0,0,0,0,1,0, 0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        add(0,2,0,0,0,0,0, 2,0,0,0,0,0,0);
        add(0,2,0,0,0,0,0, 4,0,0,0,0,0,0);
        add(0,0,1,0,0,0,0, 1,1,0,0,0,0,1);
        add(0,0,0,0,0,1,0, 1,0,0,1,0,0,1);
        add(0,0,0,0,0,0,1, 0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        add(0,1,0,0,0,0,0, 1,0,0,0,0,0,0);
        add(0,0,1,3,0,0,0, 1,0,0,0,0,1,0);
        add(0,0,0,0,0,0,0, 1,0,0,0,0,0,0);
        add(0,0,0,0,1,0,0, 1,0,0,1,0,0,1);
        add(0,0,0,0,0,0,1, 0,0,0,0,0,0,0);
        add(0,2,0,0,0,0,0, 2,0,0,0,0,0,0);
        add(0,2,0,0,0,0,0, 4,0,0,0,0,0,0);
        add(0,2,0,0,0,0,0, 6,0,0,0,0,0,0);
        add(0,2,0,0,0,0,0, 8,0,0,0,0,0,0);
        add(0,2,0,0,0,0,0, 10,0,0,0,0,0,0);
        add(0,2,0,0,0,0,0, 10,0,0,0,1,0,0);
        add(0,3,0,0,0,0,0, 10,0,0,0,1,0,0);
        add(0,0,1,1,0,0,0, 6,1,1,0,0,0,1);
        add(0,1,0,0,0,0,0, 6,1,1,0,1,0,1);
        add(0,0,0,0,0,1,0, 6,0,1,1,0,0,1);
        add(0,0,0,0,0,0,1, 5,0,1,1,0,0,1);
        add(0,0,0,0,0,0,0, 5,0,1,1,0,0,1);
        add(1,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        add(0,2,0,0,0,0,0, 2,0,0,0,0,0,0);
        add(0,2,0,0,0,0,0, 4,0,0,0,0,0,0);
        add(0,0,1,2,0,0,0, 2,1,2,0,0,0,1);
        add(1,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        add(0,0,0,0,0,1,0, 0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,1, 0,0,0,0,0,0,0);
        add(0,1,1,2,0,0,0, 1,0,0,0,0,1,0);
        add(0,2,1,2,0,0,0, 3,0,0,0,0,1,0);
        add(0,2,1,0,0,0,0, 2,1,0,0,0,0,1);
        add(0,0,0,0,0,1,0, 2,0,0,1,0,0,1);
        add(0,0,0,0,0,0,1, 1,0,0,1,0,0,1);
        add(0,0,0,0,0,0,1, 0,0,0,0,0,0,0);
        add(0,1,1,2,1,0,0, 1,0,0,1,0,0,1);
        add(0,0,0,0,0,0,1, 0,0,0,0,0,0,0);
        add(0,0,0,0,1,0,0, 0,0,0,0,0,0,0);

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < tv.size(); k++) begin
            drive(tv[k].rst, tv[k].in, tv[k].sv, tv[k].sel,
                  tv[k].can, tv[k].dack, tv[k].cack);
            check($sformatf("vec%0d", k), outs(),
                  {tv[k].cr, tv[k].dr, tv[k].id, tv[k].cq,
                   tv[k].rej, tv[k].nak, tv[k].bsy});
        end

        // idle timeout refunds held credit
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < TMO - 1; k++) drive(0, 0, 0, 0, 0, 0, 0);
        check("tmo_before", outs(), {4'd1, 7'b0000000});
        drive(0, 0, 0, 0, 0, 0, 0);
        check("tmo_fire", outs(), {4'd1, 7'b0001001});
        drive(0, 0, 0, 0, 0, 0, 1);
        check("tmo_refund", outs(), {4'd0, 7'b0000000});

        // random traffic against the model
        drive(1, 0, 0, 0, 0, 0, 0);
        model(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4000; k++) begin
            logic r, sv, c, da, ca;
            logic [1:0] i, s;
            bit quiet;
            quiet = ((k / 150) % 2) == 1;
            r  = ($urandom_range(0, 299) == 0);
            i  = quiet ? (($urandom_range(0, 39) == 0) ? 2'b01 : 2'b00)
                       : 2'($urandom_range(0, 3));
            sv = quiet ? 1'b0 : ($urandom_range(0, 3) == 0);
            s  = 2'($urandom_range(0, 3));
            c  = quiet ? 1'b0 : ($urandom_range(0, 15) == 0);
            da = ($urandom_range(0, 2) == 0);
            ca = ($urandom_range(0, 1) == 0);
            drive(r, i, sv, s, c, da, ca);
            model(r, i, sv, s, c, da, ca);
            check($sformatf("rnd%0d", k), outs(), model_outs());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
